// File: rtl/muls_pkg.sv
// -----------------------------------------------------------------------------
// muls_pkg
// Definitions shared by the sequential signed multiplier and its pin wrapper:
//   - FSM state encodings (ST_IDLE / ST_RUN / ST_DONE)
//   - Booth operation codes (BOOTH_NOP / BOOTH_ADD / BOOTH_SUB)
//   - io_in / io_out bit positions used by the top-level pin wrapper
//   - booth_op(): decodes the {Q[0], q_m1} pair into a Booth operation
// -----------------------------------------------------------------------------
package muls_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] BOOTH_NOP = 2'd0;
    localparam logic [1:0] BOOTH_ADD = 2'd1;
    localparam logic [1:0] BOOTH_SUB = 2'd2;

    // Pin-wrapper bit ids (3x3 build): io_in = {y, x, start}, io_out = {s, p, rdy, busy}
    localparam int IO_IN_START  = 0;
    localparam int IO_IN_X_LSB  = 1;
    localparam int IO_IN_Y_LSB  = 4;
    localparam int IO_OUT_BUSY  = 0;
    localparam int IO_OUT_RDY   = 1;
    localparam int IO_OUT_P_LSB = 2;
    localparam int IO_OUT_S     = 8;

    // Radix-2 Booth recoding of the current multiplier bit and the bit shifted out before it
    function automatic logic [1:0] booth_op(input logic q0, input logic q_m1);
        case ({q0, q_m1})
            2'b01:   booth_op = BOOTH_ADD;
            2'b10:   booth_op = BOOTH_SUB;
            default: booth_op = BOOTH_NOP;
        endcase
    endfunction

endpackage

// File: rtl/muls_booth_step.sv
// -----------------------------------------------------------------------------
// muls_booth_step
// One combinational radix-2 Booth iteration: conditional add/subtract of the
// multiplicand into the accumulator, then an arithmetic right shift of
// {A, Q, q_m1}.
// Ports:
//   a         in   X_WIDTH+1  accumulator (one guard bit above the multiplicand)
//   q         in   Y_WIDTH    multiplier / low product bits
//   q_m1      in   1          bit shifted out on the previous step
//   m         in   X_WIDTH+1  sign-extended multiplicand
//   a_next    out  X_WIDTH+1  accumulator after add/sub and shift
//   q_next    out  Y_WIDTH    Q after shift
//   q_m1_next out  1          new shifted-out bit
// -----------------------------------------------------------------------------
module muls_booth_step
    import muls_pkg::*;
#(
    parameter int X_WIDTH = 3,
    parameter int Y_WIDTH = 3
) (
    input  logic [X_WIDTH:0]   a,
    input  logic [Y_WIDTH-1:0] q,
    input  logic               q_m1,
    input  logic [X_WIDTH:0]   m,
    output logic [X_WIDTH:0]   a_next,
    output logic [Y_WIDTH-1:0] q_next,
    output logic               q_m1_next
);

    logic [X_WIDTH:0] sum_s;

    // Booth add/subtract; the guard bit keeps A-M exact for the most negative x
    always_comb begin
        case (booth_op(q[0], q_m1))
            BOOTH_ADD: sum_s = a + m;
            BOOTH_SUB: sum_s = a - m;
            default:   sum_s = a;
        endcase
    end

    // Arithmetic right shift of the concatenation {sum, Q, q_m1}
    always_comb begin
        a_next    = {sum_s[X_WIDTH], sum_s[X_WIDTH:1]};
        q_next    = {sum_s[0], q[Y_WIDTH-1:1]};
        q_m1_next = q[0];
    end

endmodule

// File: rtl/muls_seq_xnyn.sv
// -----------------------------------------------------------------------------
// muls_seq_xnyn
// Sequential X_WIDTH x Y_WIDTH two's-complement multiplier, radix-2 Booth,
// one step per clock, Y_WIDTH clocks from accept to result.
// Optional feature macro: MULS_SIGN_OUT_EN
//   defined   : p = |product|, extra output s = product sign
//   undefined : p = product in two's complement, no s port
// Ports:
//   clk    in   1        rising-edge clock
//   reset  in   1        asynchronous active-low reset
//   start  in   1        request, accepted while not busy (or on the result edge)
//   x      in   X_WIDTH  multiplicand, captured on the accept edge
//   y      in   Y_WIDTH  multiplier, captured on the accept edge
//   busy   out  1        multiplication in progress
//   rdy    out  1        p (and s) hold a fresh result
//   p      out  P_WIDTH  product
//   s      out  1        product sign (MULS_SIGN_OUT_EN only)
// -----------------------------------------------------------------------------
module muls_seq_xnyn
    import muls_pkg::*;
#(
    parameter int X_WIDTH = 3,
    parameter int Y_WIDTH = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [X_WIDTH-1:0]         x,
    input  logic [Y_WIDTH-1:0]         y,
    output logic                       busy,
    output logic                       rdy,
    output logic [X_WIDTH+Y_WIDTH-1:0] p
`ifdef MULS_SIGN_OUT_EN
    ,
    output logic                       s
`endif
);

    localparam int P_WIDTH = X_WIDTH + Y_WIDTH;
    localparam int CNT_W   = $clog2(Y_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Y_WIDTH - 1);

    logic [1:0]         state_r;
    logic [CNT_W-1:0]   count_r;
    logic [X_WIDTH:0]   a_r;
    logic [X_WIDTH:0]   m_r;
    logic [Y_WIDTH-1:0] q_r;
    logic               q_m1_r;
    logic               busy_r;
    logic               rdy_r;
    logic [P_WIDTH-1:0] p_r;
`ifdef MULS_SIGN_OUT_EN
    logic               s_r;
`endif

    logic [X_WIDTH:0]   a_next_s;
    logic [Y_WIDTH-1:0] q_next_s;
    logic               q_m1_next_s;
    logic               last_step_s;
    logic               accept_s;
    logic [P_WIDTH-1:0] product_s;
    logic [P_WIDTH-1:0] p_value_s;
    logic               s_value_s;

    muls_booth_step #(
        .X_WIDTH (X_WIDTH),
        .Y_WIDTH (Y_WIDTH)
    ) u_step (
        .a         (a_r),
        .q         (q_r),
        .q_m1      (q_m1_r),
        .m         (m_r),
        .a_next    (a_next_s),
        .q_next    (q_next_s),
        .q_m1_next (q_m1_next_s)
    );

    // Control decode: a new request is taken when idle/done, and also on the
    // final step edge so that back-to-back products come every Y_WIDTH clocks
    always_comb begin
        last_step_s = (state_r == ST_RUN) && (count_r == CNT_LAST);
        if (state_r == ST_RUN) begin
            accept_s = start && last_step_s;
        end else begin
            accept_s = start;
        end
    end

    // Result formatting; the low P_WIDTH bits of {A,Q} after the last step hold the exact product
    always_comb begin
        product_s = {a_next_s[X_WIDTH-1:0], q_next_s};
        s_value_s = product_s[P_WIDTH-1];
`ifdef MULS_SIGN_OUT_EN
        if (s_value_s) begin
            p_value_s = -product_s;
        end else begin
            p_value_s = product_s;
        end
`else
        p_value_s = product_s;
`endif
    end

    // FSM: IDLE/DONE wait for start, RUN steps until the last Booth step
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (accept_s) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_RUN: begin
                    if (last_step_s && !accept_s) begin
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Booth datapath and step counter: load on accept, step while running
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_r     <= '0;
            m_r     <= '0;
            q_r     <= '0;
            q_m1_r  <= 1'b0;
            count_r <= '0;
        end else if (accept_s) begin
            a_r     <= '0;
            m_r     <= {x[X_WIDTH-1], x};
            q_r     <= y;
            q_m1_r  <= 1'b0;
            count_r <= '0;
        end else if (state_r == ST_RUN) begin
            a_r     <= a_next_s;
            q_r     <= q_next_s;
            q_m1_r  <= q_m1_next_s;
            count_r <= count_r + CNT_W'(1);
        end else begin
            a_r     <= a_r;
            m_r     <= m_r;
            q_r     <= q_r;
            q_m1_r  <= q_m1_r;
            count_r <= count_r;
        end
    end

    // Output registers; rdy is cleared on the next step after a chained accept
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r <= 1'b0;
            rdy_r  <= 1'b0;
            p_r    <= '0;
`ifdef MULS_SIGN_OUT_EN
            s_r    <= 1'b0;
`endif
        end else if (last_step_s) begin
            busy_r <= accept_s;
            rdy_r  <= 1'b1;
            p_r    <= p_value_s;
`ifdef MULS_SIGN_OUT_EN
            s_r    <= s_value_s;
`endif
        end else if (accept_s || (state_r == ST_RUN)) begin
            busy_r <= 1'b1;
            rdy_r  <= 1'b0;
        end else begin
            busy_r <= busy_r;
            rdy_r  <= rdy_r;
        end
    end

    assign busy = busy_r;
    assign rdy  = rdy_r;
    assign p    = p_r;
`ifdef MULS_SIGN_OUT_EN
    assign s    = s_r;
`else
    logic unused_s;
    assign unused_s = s_value_s;
`endif

endmodule

// File: tb/tb_muls_seq_xnyn.sv
// -----------------------------------------------------------------------------
// tb_muls_seq_xnyn
// Self-checking bench: a 3x3 instance driven from a vector table and
// hand-written corner sequences (results checked through a scoreboard queue),
// plus an 8x5 instance swept exhaustively against x*y.
// Works with or without MULS_SIGN_OUT_EN defined.
// -----------------------------------------------------------------------------
module tb_muls_seq_xnyn;

    typedef struct {
        int x;
        int y;
        int prod;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        start_a = 1'b0;
    logic [2:0]  x_a = 3'd0;
    logic [2:0]  y_a = 3'd0;
    logic        busy_a;
    logic        rdy_a;
    logic [5:0]  p_a;
    logic        start_b = 1'b0;
    logic [7:0]  x_b = 8'd0;
    logic [4:0]  y_b = 5'd0;
    logic        busy_b;
    logic        rdy_b;
    logic [12:0] p_b;
`ifdef MULS_SIGN_OUT_EN
    logic        s_a;
    logic        s_b;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t sb_q[$];
    vec_t tbl[12];

    muls_seq_xnyn #(.X_WIDTH(3), .Y_WIDTH(3)) dut_a (
        .clk   (clk),
        .reset (reset),
        .start (start_a),
        .x     (x_a),
        .y     (y_a),
        .busy  (busy_a),
        .rdy   (rdy_a),
        .p     (p_a)
`ifdef MULS_SIGN_OUT_EN
        ,
        .s     (s_a)
`endif
    );

    muls_seq_xnyn #(.X_WIDTH(8), .Y_WIDTH(5)) dut_b (
        .clk   (clk),
        .reset (reset),
        .start (start_b),
        .x     (x_b),
        .y     (y_b),
        .busy  (busy_b),
        .rdy   (rdy_b),
        .p     (p_b)
`ifdef MULS_SIGN_OUT_EN
        ,
        .s     (s_b)
`endif
    );

    // Expected p encoding for a given mathematical product
    function automatic logic [31:0] enc(input int prod);
`ifdef MULS_SIGN_OUT_EN
        enc = (prod < 0) ? -prod : prod;
`else
        enc = prod;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, want, want);
        end
    endtask

    task automatic push_exp(input int xv, input int yv, input int pv);
        vec_t v;
        v.x = xv;
        v.y = yv;
        v.prod = pv;
        sb_q.push_back(v);
    endtask

    // Scoreboard for the 3x3 instance: each rising edge of rdy pops one expected result
    logic rdy_prev = 1'b0;
    always @(negedge clk) begin : mon_a
        vec_t e;
        logic [31:0] ev;
        if (rdy_a && !rdy_prev) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: result p=%0d with empty queue", p_a);
            end else begin
                e  = sb_q.pop_front();
                ev = enc(e.prod);
                n_tests++;
                if (p_a !== ev[5:0]) begin
                    n_fail++;
                    $display("FAIL sb_p %0d*%0d: got %0d expected %0d", e.x, e.y, p_a, ev[5:0]);
                end
`ifdef MULS_SIGN_OUT_EN
                n_tests++;
                if (s_a !== (e.prod < 0)) begin
                    n_fail++;
                    $display("FAIL sb_s %0d*%0d: got %0b expected %0b", e.x, e.y, s_a, (e.prod < 0));
                end
`endif
            end
        end
        rdy_prev = rdy_a;
    end

    // One isolated 3x3 product: accept, then expect rdy exactly 3 clocks later
    task automatic run_a(input int xv, input int yv, input int pv);
        int lat;
        @(negedge clk);
        x_a = 3'(xv);
        y_a = 3'(yv);
        start_a = 1'b1;
        push_exp(xv, yv, pv);
        @(posedge clk);
        #1;
        start_a = 1'b0;
        chk("accept_busy", 32'(busy_a), 32'd1);
        chk("accept_rdy", 32'(rdy_a), 32'd0);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!rdy_a && lat < 10);
        chk("latency_a", lat, 3);
        chk("busy_done_a", 32'(busy_a), 32'd0);
    endtask

    initial begin : main
        int lat;
        logic [31:0] ev;

        tbl[0]  = '{3, -2, -6};
        tbl[1]  = '{-4, -4, 16};
        tbl[2]  = '{0, -3, 0};
        tbl[3]  = '{-3, 0, 0};
        tbl[4]  = '{1, 1, 1};
        tbl[5]  = '{-1, 3, -3};
        tbl[6]  = '{2, -4, -8};
        tbl[7]  = '{3, 3, 9};
        tbl[8]  = '{-4, 3, -12};
        tbl[9]  = '{3, -4, -12};
        tbl[10] = '{-1, -1, 1};
        tbl[11] = '{-4, 1, -4};

        // Reset state
        #1 reset = 1'b0;
        #1;
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_rdy", 32'(rdy_a), 32'd0);
        chk("rst_p", 32'(p_a), 32'd0);
        chk("rst_busy_b", 32'(busy_b), 32'd0);
`ifdef MULS_SIGN_OUT_EN
        chk("rst_s", 32'(s_a), 32'd0);
`endif
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Table-driven products
        for (int i = 0; i < 12; i++) begin
            run_a(tbl[i].x, tbl[i].y, tbl[i].prod);
        end

        // start pulsed mid-RUN with new operands: ignored
        @(negedge clk);
        x_a = 3'(3);
        y_a = 3'(-2);
        start_a = 1'b1;
        push_exp(3, -2, -6);
        @(posedge clk);
        #1;
        start_a = 1'b0;
        @(negedge clk);
        x_a = 3'(2);
        y_a = 3'(2);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        chk("midrun_busy1", 32'(busy_a), 32'd1);
        chk("midrun_rdy1", 32'(rdy_a), 32'd0);
        @(posedge clk);
        #1;
        start_a = 1'b0;
        chk("midrun_busy2", 32'(busy_a), 32'd1);
        @(posedge clk);
        #1;
        chk("midrun_rdy3", 32'(rdy_a), 32'd1);
        chk("midrun_busy3", 32'(busy_a), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("midrun_no_rerun", 32'(busy_a), 32'd0);
        chk("midrun_rdy_hold", 32'(rdy_a), 32'd1);

        // Back-to-back with start held: 1*1, -1*3, 2*-4, results every 3 clocks
        @(negedge clk);
        x_a = 3'(1);
        y_a = 3'(1);
        start_a = 1'b1;
        push_exp(1, 1, 1);
        @(posedge clk);
        #1;
        chk("b2b_rdy_accept0", 32'(rdy_a), 32'd0);
        x_a = 3'(-1);
        y_a = 3'(3);
        push_exp(-1, 3, -3);
        for (int e = 1; e <= 9; e++) begin
            @(posedge clk);
            #1;
            chk("b2b_rdy", 32'(rdy_a), (e % 3 == 0) ? 32'd1 : 32'd0);
            chk("b2b_busy", 32'(busy_a), (e < 9) ? 32'd1 : 32'd0);
            if (e == 3) begin
                x_a = 3'(2);
                y_a = 3'(-4);
                push_exp(2, -4, -8);
            end else if (e == 6) begin
                start_a = 1'b0;
            end else begin
                start_a = start_a;
            end
        end

        // Asynchronous reset one clock into RUN
        @(negedge clk);
        x_a = 3'(3);
        y_a = 3'(3);
        start_a = 1'b1;
        push_exp(3, 3, 9);
        @(posedge clk);
        #1;
        start_a = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_busy", 32'(busy_a), 32'd0);
        chk("abort_rdy", 32'(rdy_a), 32'd0);
        chk("abort_p", 32'(p_a), 32'd0);
`ifdef MULS_SIGN_OUT_EN
        chk("abort_s", 32'(s_a), 32'd0);
`endif
        sb_q.delete();
        @(negedge clk);
        reset = 1'b1;
        run_a(2, 3, 6);

        // Exhaustive 8x5 sweep
        for (int xi = -128; xi < 128; xi++) begin
            for (int yi = -16; yi < 16; yi++) begin
                @(negedge clk);
                x_b = 8'(xi);
                y_b = 5'(yi);
                start_b = 1'b1;
                @(posedge clk);
                #1;
                start_b = 1'b0;
                lat = 0;
                do begin
                    @(posedge clk);
                    #1;
                    lat++;
                end while (!rdy_b && lat < 12);
                chk("sweep_latency", lat, 5);
                ev = enc(xi * yi);
                n_tests++;
                if (p_b !== ev[12:0]) begin
                    n_fail++;
                    $display("FAIL sweep_p %0d*%0d: got %0d expected %0d", xi, yi, p_b, ev[12:0]);
                end
`ifdef MULS_SIGN_OUT_EN
                n_tests++;
                if (s_b !== ((xi * yi) < 0)) begin
                    n_fail++;
                    $display("FAIL sweep_s %0d*%0d: got %0b expected %0b", xi, yi, s_b, ((xi * yi) < 0));
                end
`endif
            end
        end

        @(negedge clk);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: %0d results never produced, expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
